// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
// Owner encoding and pending-response bundle live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam int MEM_SIZE_DEF = 512;
    localparam int MAX_WAIT_DEF = 2;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef struct packed {
        owner_t owner;
        logic   is_store;
        logic   err;
    } pend_t;

endpackage

// File: rtl/mem_addr_check.sv
// Word alignment and range check for one requester address.
// Pure combinational; flags any address the memory cannot serve.
module mem_addr_check
    import mem_arb_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic [31:0] addr,
    output logic        err
);

    localparam logic [31:0] LAST = 32'(MEM_SIZE - 4);

    logic misaligned;
    logic out_of_range;

    assign misaligned   = (addr[1:0] & ALIGN_MASK) != 2'b00;
    assign out_of_range = addr > LAST;
    assign err          = misaligned | out_of_range;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IF, LS) arbiter for a single-port 1-cycle memory.
// LS has priority; IF is forced through after MAX_WAIT denials.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_ip,
    input  logic [31:0] if_addr_ip,
    output logic        if_gnt_op,
    output logic        if_rvalid_op,
    output logic [31:0] if_rdata_op,
    output logic        if_err_op,
    input  logic        ls_req_ip,
    input  logic        ls_we_ip,
    input  logic [31:0] ls_addr_ip,
    input  logic [31:0] ls_wdata_ip,
    output logic        ls_gnt_op,
    output logic        ls_rvalid_op,
    output logic [31:0] ls_rdata_op,
    output logic        ls_err_op,
    output logic        mem_ren_op,
    output logic        mem_wren_op,
    output logic [31:0] mem_addr_op,
    output logic [31:0] mem_wdata_op,
    input  logic [31:0] mem_rdata_ip
);

    localparam int CW = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nxt;
    logic          starved;
    logic          if_win;
    logic          ls_win;
    logic          if_err;
    logic          ls_err;
    pend_t         pend;
    pend_t         pend_nxt;

    mem_addr_check #(.MEM_SIZE(MEM_SIZE)) u_if_chk (
        .addr (if_addr_ip),
        .err  (if_err)
    );

    mem_addr_check #(.MEM_SIZE(MEM_SIZE)) u_ls_chk (
        .addr (ls_addr_ip),
        .err  (ls_err)
    );

    // Grants are gated by rst_n so nothing reaches memory during reset.
    assign starved = starve_cnt == CNT_MAX;
    assign if_win  = rst_n & if_req_ip & (~ls_req_ip | starved);
    assign ls_win  = rst_n & ls_req_ip & ~if_win;

    assign if_gnt_op = if_win;
    assign ls_gnt_op = ls_win;

    always_comb begin
        mem_ren_op   = 1'b0;
        mem_wren_op  = 1'b0;
        mem_addr_op  = 32'd0;
        mem_wdata_op = 32'd0;
        pend_nxt     = '{owner: OWN_NONE, is_store: 1'b0, err: 1'b0};
        unique case (1'b1)
            if_win: begin
                mem_ren_op     = ~if_err;
                mem_addr_op    = if_addr_ip;
                pend_nxt.owner = OWN_IF;
                pend_nxt.err   = if_err;
            end
            ls_win: begin
                mem_ren_op        = ~ls_we_ip & ~ls_err;
                mem_wren_op       = ls_we_ip & ~ls_err;
                mem_addr_op       = ls_addr_ip;
                mem_wdata_op      = ls_we_ip ? ls_wdata_ip : 32'd0;
                pend_nxt.owner    = OWN_LS;
                pend_nxt.is_store = ls_we_ip;
                pend_nxt.err      = ls_err;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (!if_req_ip || if_win)
            starve_nxt = '0;
        else if (starve_cnt != CNT_MAX)
            starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '{owner: OWN_NONE, is_store: 1'b0, err: 1'b0};
            starve_cnt <= '0;
        end else begin
            pend       <= pend_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign if_rvalid_op = pend.owner == OWN_IF;
    assign if_err_op    = if_rvalid_op & pend.err;
    assign if_rdata_op  = (if_rvalid_op & ~pend.err) ? mem_rdata_ip : 32'd0;

    assign ls_rvalid_op = pend.owner == OWN_LS;
    assign ls_err_op    = ls_rvalid_op & pend.err;
    assign ls_rdata_op  = (ls_rvalid_op & ~pend.err & ~pend.is_store)
                        ? mem_rdata_ip : 32'd0;

endmodule
